// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one pipelined adder among N requesters.
// Each sum comes back tagged with the id of the requester that issued it.

module add_arbiter_lane #(
  parameter int N   = 4,
  parameter int IDX = 0,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   valid,
  input  logic [IDW-1:0] ptr,
  output logic           gnt
);
  int   d_me;
  int   d_j;
  logic blocked;

  // Rank requesters by circular distance from ptr; nearest valid one wins.
  always_comb begin
    d_me = IDX + N - int'(ptr);
    if (d_me >= N) d_me = d_me - N;
    blocked = 1'b0;
    d_j = 0;
    for (int j = 0; j < N; j++) begin
      d_j = j + N - int'(ptr);
      if (d_j >= N) d_j = d_j - N;
      if (valid[j] && (d_j < d_me)) blocked = 1'b1;
    end
    gnt = valid[IDX] & ~blocked;
  end
endmodule

module add_arbiter #(
  parameter int N       = 4,
  parameter int ADD_LAT = 1,
  parameter int WIDTH   = 8,
  parameter int IDW     = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*WIDTH-1:0] req_a,
  input  logic [N*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]   add_a,
  output logic [WIDTH-1:0]   add_b,
  input  logic [WIDTH-1:0]   add_f,
  output logic               res_valid,
  output logic [IDW-1:0]     res_id,
  output logic [WIDTH-1:0]   res_f
);
  logic [IDW-1:0]              ptr;
  logic [IDW-1:0]              gid;
  logic [N-1:0]                gnt;
  logic                        xfer;
  logic [ADD_LAT-1:0]          vld_pipe;
  logic [ADD_LAT-1:0][IDW-1:0] id_pipe;

  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      add_arbiter_lane #(.N(N), .IDX(i), .IDW(IDW)) u_lane (
        .valid (req_valid),
        .ptr   (ptr),
        .gnt   (gnt[i])
      );
    end
  endgenerate

  always_comb begin
    req_ready = reset ? '0 : gnt;
    add_a     = '0;
    add_b     = '0;
    gid       = '0;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i]) begin
        add_a = req_a[i*WIDTH +: WIDTH];
        add_b = req_b[i*WIDTH +: WIDTH];
        gid   = IDW'(i);
      end
    end
  end

  assign xfer = |req_ready;

  // Explicit wrap keeps ptr in range when N is not a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (xfer) begin
      if (gid == IDW'(N-1)) ptr <= '0;
      else                  ptr <= gid + IDW'(1);
    end
  end

  // Ids only advance alongside a valid bit so res_id holds between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[0] <= xfer;
      if (xfer) id_pipe[0] <= gid;
      for (int s = 1; s < ADD_LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        if (vld_pipe[s-1]) id_pipe[s] <= id_pipe[s-1];
      end
    end
  end

  assign res_valid = vld_pipe[ADD_LAT-1];
  assign res_id    = id_pipe[ADD_LAT-1];
  assign res_f     = add_f;
endmodule

// File: tb/tb_add_arbiter.sv
// Bench for add_arbiter: N=4/ADD_LAT=1 and N=3/ADD_LAT=3 instances, each with a stub
// pipelined adder, checked every cycle against a queue-based round-robin model.

module tb_add_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  typedef struct {int due; int id; int sum;} res_t;

  // instance A: N=4, ADD_LAT=1
  logic        rst_a;
  logic [3:0]  va, ra;
  logic [31:0] ain, bin;
  logic [7:0]  aa, ab, af, resf_a;
  logic        resv_a;
  logic [1:0]  resid_a;

  add_arbiter #(.N(4), .ADD_LAT(1), .WIDTH(8)) u_a (
    .clk(clk), .reset(rst_a), .req_valid(va), .req_ready(ra),
    .req_a(ain), .req_b(bin), .add_a(aa), .add_b(ab), .add_f(af),
    .res_valid(resv_a), .res_id(resid_a), .res_f(resf_a)
  );
  always @(posedge clk) af <= aa + ab;

  // instance B: N=3, ADD_LAT=3
  logic        rst_b;
  logic [2:0]  vb, rb;
  logic [23:0] bina, binb;
  logic [7:0]  ba, bb, bf, bf0, bf1, resf_b;
  logic        resv_b;
  logic [1:0]  resid_b;

  add_arbiter #(.N(3), .ADD_LAT(3), .WIDTH(8)) u_b (
    .clk(clk), .reset(rst_b), .req_valid(vb), .req_ready(rb),
    .req_a(bina), .req_b(binb), .add_a(ba), .add_b(bb), .add_f(bf),
    .res_valid(resv_b), .res_id(resid_b), .res_f(resf_b)
  );
  always @(posedge clk) begin
    bf0 <= ba + bb;
    bf1 <= bf0;
    bf  <= bf1;
  end

  // reference model state
  int         ptr_a, ptr_b, last_id_a, last_id_b;
  res_t       qa[$], qb[$];
  logic [3:0] obs_ra;
  logic [2:0] obs_rb;
  logic [7:0] obs_f_a;

  function automatic int grant_of(input int v, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (p + k) % n;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  task automatic step_a(input logic [3:0] v, input logic [3:0][7:0] a, input logic [3:0][7:0] b);
    int g; logic [3:0] er; logic [7:0] ea, eb; logic ev;
    va = v; ain = a; bin = b;
    @(negedge clk);
    g = grant_of(int'(v), ptr_a, 4);
    er = '0; ea = '0; eb = '0;
    if (g >= 0) begin er = 4'(1 << g); ea = a[g]; eb = b[g]; end
    obs_ra = ra;
    nvec++; if (ra !== er) begin nerr++; $display("FAIL ready_a: got %b want %b cyc %0d", ra, er, cyc); end
    nvec++; if ({aa, ab} !== {ea, eb}) begin nerr++; $display("FAIL operands_a: got %h/%h want %h/%h cyc %0d", aa, ab, ea, eb, cyc); end
    ev = (qa.size() > 0) && (qa[0].due <= cyc);
    nvec++; if (resv_a !== ev) begin nerr++; $display("FAIL res_valid_a: got %b want %b cyc %0d", resv_a, ev, cyc); end
    if (ev) begin
      obs_f_a = resf_a;
      nvec++;
      if (resid_a !== 2'(qa[0].id) || resf_a !== 8'(qa[0].sum)) begin
        nerr++; $display("FAIL result_a: got id %0d f %h want id %0d f %h", resid_a, resf_a, qa[0].id, qa[0].sum);
      end
      last_id_a = qa[0].id;
      void'(qa.pop_front());
    end
    if (g >= 0) begin
      ptr_a = (g + 1) % 4;
      qa.push_back('{cyc + 1, g, (int'(a[g]) + int'(b[g])) % 256});
    end
    @(posedge clk); #1;
    nvec++; if (u_a.ptr !== 2'(ptr_a)) begin nerr++; $display("FAIL ptr_a: got %0d want %0d", u_a.ptr, ptr_a); end
  endtask

  task automatic step_b(input logic [2:0] v, input logic [2:0][7:0] a, input logic [2:0][7:0] b);
    int g; logic [2:0] er; logic [7:0] ea, eb; logic ev;
    vb = v; bina = a; binb = b;
    @(negedge clk);
    g = grant_of(int'(v), ptr_b, 3);
    er = '0; ea = '0; eb = '0;
    if (g >= 0) begin er = 3'(1 << g); ea = a[g]; eb = b[g]; end
    obs_rb = rb;
    nvec++; if (rb !== er) begin nerr++; $display("FAIL ready_b: got %b want %b cyc %0d", rb, er, cyc); end
    nvec++; if ({ba, bb} !== {ea, eb}) begin nerr++; $display("FAIL operands_b: got %h/%h want %h/%h cyc %0d", ba, bb, ea, eb, cyc); end
    ev = (qb.size() > 0) && (qb[0].due <= cyc);
    nvec++; if (resv_b !== ev) begin nerr++; $display("FAIL res_valid_b: got %b want %b cyc %0d", resv_b, ev, cyc); end
    if (ev) begin
      nvec++;
      if (resid_b !== 2'(qb[0].id) || resf_b !== 8'(qb[0].sum)) begin
        nerr++; $display("FAIL result_b: got id %0d f %h want id %0d f %h", resid_b, resf_b, qb[0].id, qb[0].sum);
      end
      last_id_b = qb[0].id;
      void'(qb.pop_front());
    end
    if (g >= 0) begin
      ptr_b = (g + 1) % 3;
      qb.push_back('{cyc + 3, g, (int'(a[g]) + int'(b[g])) % 256});
    end
    @(posedge clk); #1;
    nvec++; if (u_b.ptr !== 2'(ptr_b)) begin nerr++; $display("FAIL ptr_b: got %0d want %0d", u_b.ptr, ptr_b); end
  endtask

  task automatic test_reset_a(input int n);
    rst_a = 1'b1; va = 4'hF; ain = $urandom; bin = $urandom;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      nvec++; if (ra !== 4'b0) begin nerr++; $display("FAIL reset_ready_a: got %b want 0", ra); end
      if (c > 0) begin
        nvec++; if (resv_a !== 1'b0) begin nerr++; $display("FAIL reset_valid_a: got %b want 0", resv_a); end
      end
      @(posedge clk); #1;
    end
    rst_a = 1'b0; va = '0;
    ptr_a = 0; last_id_a = 0; qa.delete();
    nvec++; if (u_a.ptr !== 2'd0 || resid_a !== 2'd0) begin nerr++; $display("FAIL reset_state_a: got ptr %0d id %0d want 0 0", u_a.ptr, resid_a); end
  endtask

  task automatic test_reset_b(input int n);
    rst_b = 1'b1; vb = 3'b111; bina = 24'($urandom); binb = 24'($urandom);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      nvec++; if (rb !== 3'b0) begin nerr++; $display("FAIL reset_ready_b: got %b want 0", rb); end
      if (c > 0) begin
        nvec++; if (resv_b !== 1'b0) begin nerr++; $display("FAIL reset_valid_b: got %b want 0", resv_b); end
      end
      @(posedge clk); #1;
    end
    rst_b = 1'b0; vb = '0;
    ptr_b = 0; last_id_b = 0; qb.delete();
    nvec++; if (u_b.ptr !== 2'd0 || resid_b !== 2'd0) begin nerr++; $display("FAIL reset_state_b: got ptr %0d id %0d want 0 0", u_b.ptr, resid_b); end
  endtask

  task automatic test_single;
    logic [3:0][7:0] a, b;
    a = '0; b = '0; a[2] = 8'd5; b[2] = 8'd7;
    step_a(4'b0100, a, b);
    nvec++; if (obs_ra !== 4'b0100) begin nerr++; $display("FAIL single_ready: got %b want 0100", obs_ra); end
    step_a(4'b0000, $urandom, $urandom);
    nvec++; if (obs_f_a !== 8'd12 || last_id_a != 2) begin nerr++; $display("FAIL single_result: got f %0d want 12", obs_f_a); end
    nvec++; if (u_a.ptr !== 2'd3) begin nerr++; $display("FAIL single_ptr: got %0d want 3", u_a.ptr); end
  endtask

  task automatic test_all_valid;
    logic [3:0][7:0] a, b;
    for (int k = 0; k < 4; k++) begin a[k] = 8'(k); b[k] = 8'd10; end
    test_reset_a(2);
    for (int i = 0; i < 8; i++) begin
      step_a(4'hF, a, b);
      nvec++; if (obs_ra !== 4'(1 << (i % 4))) begin nerr++; $display("FAIL all_valid_grant %0d: got %b want %b", i, obs_ra, 4'(1 << (i % 4))); end
    end
    step_a(4'b0000, $urandom, $urandom);
  endtask

  task automatic test_wrap;
    logic [3:0][7:0] a, b;
    a = $urandom; b = $urandom; a[0] = 8'hF0; b[0] = 8'h20;
    step_a(4'b0001, a, b);
    step_a(4'b0000, $urandom, $urandom);
    nvec++; if (obs_f_a !== 8'h10) begin nerr++; $display("FAIL wrap_sum: got %h want 10", obs_f_a); end
  endtask

  task automatic test_fairness;
    test_reset_a(2);
    for (int i = 0; i < 4; i++) begin
      step_a(4'b1010, $urandom, $urandom);
      nvec++;
      if (obs_ra !== ((i % 2 == 0) ? 4'b0010 : 4'b1000)) begin
        nerr++; $display("FAIL fairness_grant %0d: got %b", i, obs_ra);
      end
    end
  endtask

  task automatic test_idle;
    step_a(4'b0000, $urandom, $urandom);
    for (int i = 0; i < 10; i++) begin
      step_a(4'b0000, $urandom, $urandom);
      nvec++; if (resid_a !== 2'(last_id_a)) begin nerr++; $display("FAIL idle_id_hold: got %0d want %0d", resid_a, last_id_a); end
    end
  endtask

  task automatic test_random_a;
    for (int i = 0; i < 400; i++) step_a(4'($urandom_range(0, 15)), $urandom, $urandom);
    for (int i = 0; i < 2; i++) step_a(4'b0000, $urandom, $urandom);
    nvec++; if (qa.size() != 0) begin nerr++; $display("FAIL drain_a: %0d results never seen, want 0", qa.size()); end
  endtask

  task automatic test_reset_midflight;
    test_reset_b(2);
    for (int i = 0; i < 3; i++) step_b(3'b111, 24'($urandom), 24'($urandom));
    test_reset_b(2);
    for (int i = 0; i < 6; i++) step_b(3'b000, 24'($urandom), 24'($urandom));
    step_b(3'b010, 24'($urandom), 24'($urandom));
    for (int i = 0; i < 4; i++) step_b(3'b000, 24'($urandom), 24'($urandom));
    nvec++; if (qb.size() != 0 || last_id_b != 1) begin nerr++; $display("FAIL midflight_post: pending %0d id %0d want 0 1", qb.size(), last_id_b); end
  endtask

  task automatic test_random_b;
    for (int i = 0; i < 300; i++) step_b(3'($urandom_range(0, 7)), 24'($urandom), 24'($urandom));
    for (int i = 0; i < 4; i++) step_b(3'b000, 24'($urandom), 24'($urandom));
    nvec++; if (qb.size() != 0) begin nerr++; $display("FAIL drain_b: %0d results never seen, want 0", qb.size()); end
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    va = '0; vb = '0; ain = '0; bin = '0; bina = '0; binb = '0;
    ptr_a = 0; ptr_b = 0; last_id_a = 0; last_id_b = 0;
    obs_ra = '0; obs_rb = '0; obs_f_a = '0;
    @(posedge clk); #1;
    test_reset_a(2);
    test_single;
    test_all_valid;
    test_wrap;
    test_fairness;
    test_idle;
    test_random_a;
    test_reset_midflight;
    test_random_b;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
